axis_coeff_packer: RTL and testbench

- Output-side packing stage placed directly upstream of the accelerator's AXI-Stream master port (m_axis_*, to DMA S2MM).
- Consumes a narrow coefficient stream from the compute core (NTT/PWM/add-sub/SHA sampler results), zero-extends each coefficient to 32 bits and packs two per 64-bit beat.
- Generates tkeep/tlast per frame and keeps a cumulative beat counter for the write-FIFO status register.

---
 rtl/axis_coeff_packer.sv | 160 ++++++++++++++++
 tb/tb_axis_coeff_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_coeff_packer.sv
// Packs zero-extended COEF_W-bit coefficients two per 64-bit AXI-Stream beat, with per-frame tkeep/tlast.
// Optional output stall counter is enabled by defining PACKER_STALL_CNT_EN.
module axis_coeff_packer #(
  parameter int COEF_W = 23,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  coef_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [63:0]       m_axis_tdata,
  output logic [7:0]        m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [31:0]       beat_count
`ifdef PACKER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, LO, HI, DRAIN} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [31:0]      lane0_q;
  logic             tvalid_q;
  logic [63:0]      tdata_q;
  logic [7:0]       tkeep_q;
  logic             tlast_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      beat_cnt_q;

  logic             beat_hs_d;
  logic             reg_free_d;
  logic             coef_hs_d;
  logic             last_coef_d;
  logic [31:0]      coef_d;

  function automatic logic [31:0] zext(input logic [COEF_W-1:0] d);
    logic [31:0] r;
    r = 32'h0;
    r[COEF_W-1:0] = d;
    return r;
  endfunction

  // The single output register is reusable when empty or draining this cycle.
  always_comb begin
    beat_hs_d   = tvalid_q && m_axis_tready;
    reg_free_d  = !tvalid_q || m_axis_tready;
    coef_hs_d   = in_valid && in_ready;
    last_coef_d = (rem_q == LEN_W'(1));
    coef_d      = zext(in_data);
  end

  assign in_ready      = ((state_q == LO) || (state_q == HI)) && reg_free_d;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign beat_count    = beat_cnt_q;

  // Frame FSM, output beat register and cumulative beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      lane0_q    <= 32'h0;
      tvalid_q   <= 1'b0;
      tdata_q    <= 64'h0;
      tkeep_q    <= 8'h00;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      beat_cnt_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      if (beat_hs_d) begin
        tvalid_q   <= 1'b0;
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (coef_count == '0) begin
              done_q <= 1'b1;
            end else begin
              rem_q   <= coef_count;
              busy_q  <= 1'b1;
              state_q <= LO;
            end
          end
        end
        LO: begin
          if (coef_hs_d) begin
            lane0_q <= coef_d;
            rem_q   <= rem_q - LEN_W'(1);
            if (last_coef_d) begin
              // Odd-length tail: upper lane stays zero and only the low 4 bytes are kept.
              tvalid_q <= 1'b1;
              tdata_q  <= {32'h0, coef_d};
              tkeep_q  <= 8'h0F;
              tlast_q  <= 1'b1;
              state_q  <= DRAIN;
            end else begin
              state_q <= HI;
            end
          end
        end
        HI: begin
          if (coef_hs_d) begin
            rem_q    <= rem_q - LEN_W'(1);
            tvalid_q <= 1'b1;
            tdata_q  <= {coef_d, lane0_q};
            tkeep_q  <= 8'hFF;
            tlast_q  <= last_coef_d;
            state_q  <= last_coef_d ? DRAIN : LO;
          end
        end
        DRAIN: begin
          if (beat_hs_d && tlast_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PACKER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  assign stall_count = stall_cnt_q;

  // Cycles the downstream holds off a valid beat; restarts with each accepted frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else if ((state_q == IDLE) && start) begin
      stall_cnt_q <= 32'h0;
    end else if (tvalid_q && !m_axis_tready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_axis_coeff_packer.sv
// Directed bench for axis_coeff_packer with an expected-beat scoreboard and a negedge output monitor.
module tb_axis_coeff_packer;
  localparam int COEF_W = 23;
  localparam int LEN_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  coef_count;
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_data;
  logic              tvalid;
  logic              tready;
  logic [63:0]       tdata;
  logic [7:0]        tkeep;
  logic              tlast;
  logic              busy;
  logic              done;
  logic [31:0]       beat_count;
`ifdef PACKER_STALL_CNT_EN
  logic [31:0]       stall_count;
`endif

  axis_coeff_packer #(.COEF_W(COEF_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .coef_count(coef_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .busy(busy), .done(done),
    .beat_count(beat_count)
`ifdef PACKER_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int stall_exp = 0;
  logic mon_en  = 1'b0;
  logic zl_mode = 1'b0;
  logic done_pend = 1'b0;
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  logic [72:0] prev_beat = '0;
  logic [72:0] sb[$];
  logic [31:0] coef_mem [0:15];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] zx(input logic [31:0] v);
    return {9'h0, v[22:0]};
  endfunction

  task automatic push_frame(input int n);
    logic [31:0] hi;
    logic [7:0]  kp;
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) begin
        hi = zx(coef_mem[i+1]);
        kp = 8'hFF;
      end else begin
        hi = 32'h0;
        kp = 8'h0F;
      end
      sb.push_back({(i + 2 >= n), kp, hi, zx(coef_mem[i])});
    end
  endtask

  // Output monitor: scoreboard pops, hold-stability and done timing.
  always @(negedge clk) begin
    logic [72:0] e;
    if (rst || !mon_en) begin
      prev_v    = 1'b0;
      done_pend = 1'b0;
    end else begin
      if (!zl_mode) chk("done_timing", 80'(done), 80'(done_pend));
      if (done) done_cnt++;
      if (prev_v && !prev_r) chk("hold_stable", 80'({tvalid, tlast, tkeep, tdata}), 80'({1'b1, prev_beat}));
      if (tvalid && !tready) stall_exp++;
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 80'(tdata), 80'(1'b0) - 80'd1);
        end else begin
          e = sb.pop_front();
          chk("beat", 80'({tlast, tkeep, tdata}), 80'(e));
        end
      end
      done_pend = tvalid && tready && tlast;
      prev_v    = tvalid;
      prev_r    = tready;
      prev_beat = {tlast, tkeep, tdata};
    end
  end

  task automatic run_frame(input int n, input int tmode, input int dup_cyc, input int stop_after);
    int idx = 0;
    int cyc = 0;
    logic got = 1'b0;
    push_frame(n);
    @(posedge clk); #1;
    start = 1'b1; coef_count = LEN_W'(n); stall_exp = 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 400) begin
      tready     = (tmode == 0) ? 1'b1 : (cyc % 4 == 0);
      start      = (cyc == dup_cyc);
      coef_count = (cyc == dup_cyc) ? LEN_W'(2) : LEN_W'(n);
      in_valid   = (idx < n);
      in_data    = coef_mem[idx % 16][COEF_W-1:0];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (done) begin got = 1'b1; break; end
      if (stop_after > 0 && idx == stop_after) begin got = 1'b1; break; end
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    tready   = 1'b1;
    chk("frame_timeout", 80'(got), 80'(1'b1));
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; coef_count = '0; in_valid = 1'b0; in_data = '0; tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", 80'(tvalid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    chk("rst_beat_count", 80'(beat_count), 80'(0));
    chk("rst_beat", 80'({tlast, tkeep, tdata}), 80'(0));

    // Even frame.
    for (int i = 0; i < 4; i++) coef_mem[i] = 32'(i + 1);
    d0 = done_cnt;
    run_frame(4, 0, -1, 0);
    chk("even_busy_after", 80'(busy), 80'(0));
    chk("even_beat_count", 80'(beat_count), 80'(2));
    repeat (3) @(negedge clk);
    chk("even_one_done", 80'(done_cnt - d0), 80'(1));
    chk("even_sb_empty", 80'(sb.size()), 80'(0));

    // Odd frame with a full-scale coefficient.
    coef_mem[0] = 32'h7FFFFF; coef_mem[1] = 32'h1; coef_mem[2] = 32'h5;
    run_frame(3, 0, -1, 0);
    chk("odd_beat_count", 80'(beat_count), 80'(4));
    chk("odd_sb_empty", 80'(sb.size()), 80'(0));

    // Backpressure: 1 cycle ready, 3 cycles stalled.
    for (int i = 0; i < 8; i++) coef_mem[i] = 32'h100 + 32'(i * 3);
    run_frame(8, 1, -1, 0);
    chk("bp_beat_count", 80'(beat_count), 80'(8));
    chk("bp_sb_empty", 80'(sb.size()), 80'(0));
`ifdef PACKER_STALL_CNT_EN
    chk("bp_stall_count", 80'(stall_count), 80'(stall_exp));
`endif

    // Zero-length frame.
    repeat (2) @(posedge clk);
    #1 zl_mode = 1'b1; start = 1'b1; coef_count = '0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zl_done", 80'(done), 80'(1));
    chk("zl_busy", 80'(busy), 80'(0));
    chk("zl_tvalid", 80'(tvalid), 80'(0));
    @(negedge clk);
    chk("zl_done_clear", 80'(done), 80'(0));
    chk("zl_beat_count", 80'(beat_count), 80'(8));
    zl_mode = 1'b0;

    // Start while busy is ignored.
    for (int i = 0; i < 4; i++) coef_mem[i] = 32'h2A0000 + 32'(i);
    d0 = done_cnt;
    run_frame(4, 0, 2, 0);
    repeat (4) @(negedge clk);
    chk("dup_one_done", 80'(done_cnt - d0), 80'(1));
    chk("dup_idle_tvalid", 80'(tvalid), 80'(0));
    chk("dup_beat_count", 80'(beat_count), 80'(10));
    chk("dup_sb_empty", 80'(sb.size()), 80'(0));

    // Reset after the first coefficient of a 4-coefficient frame.
    for (int i = 0; i < 4; i++) coef_mem[i] = 32'h11 * 32'(i + 1);
    d0 = done_cnt;
    run_frame(4, 0, -1, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_tvalid", 80'(tvalid), 80'(0));
    chk("rst_mid_busy", 80'(busy), 80'(0));
    chk("rst_mid_beat_count", 80'(beat_count), 80'(0));
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", 80'(done_cnt - d0), 80'(0));
    coef_mem[0] = 32'h0ABCDE; coef_mem[1] = 32'h012345;
    run_frame(2, 0, -1, 0);
    chk("after_rst_beat_count", 80'(beat_count), 80'(1));
    chk("after_rst_sb_empty", 80'(sb.size()), 80'(0));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
